// File: rtl/io_map_pkg.sv
// IO bus word-offset map shared by the bus controller and its bench.
// Offsets index addr[4:2] inside the IO region.
package io_map_pkg;

    localparam logic [2:0] OFF_HEX    = 3'd0;
    localparam logic [2:0] OFF_LEDR   = 3'd1;
    localparam logic [2:0] OFF_LEDG   = 3'd2;
    localparam logic [2:0] OFF_SW     = 3'd4;
    localparam logic [2:0] OFF_SWSTAT = 3'd5;

    localparam int SWSTAT_CHG_BIT = 0;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus saturating-counter debouncer for a switch bus.
// chg_o pulses in the cycle the stable value is about to update.
module switch_debouncer #(
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SW_WIDTH-1:0] sw_i,
    output logic [SW_WIDTH-1:0] stable_o,
    output logic                chg_o
);

    localparam int CW = 16;
    localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync1_q, sync2_q, prev_q, stable_q, stable_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                smp_chg, upd;

    // The first cycle of a new sample counts as cycle one of the window.
    always_comb begin
        smp_chg  = (sync2_q != prev_q);
        cnt_d    = cnt_q;
        if (smp_chg) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
        upd      = (sync2_q != stable_q) && (cnt_d >= THRESH);
        stable_d = upd ? sync2_q : stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign chg_o    = upd;

endmodule

// File: rtl/io_bus_controller.sv
// Load/store bus splitter: memory-mapped HEX/LED/switch registers in the
// top address region, everything else forwarded to data memory.
module io_bus_controller
    import io_map_pkg::*;
#(
    parameter int DATA_BIT_WIDTH  = 32,
    parameter int IO_REGION_BITS  = 4,
    parameter int HEX_WIDTH       = 16,
    parameter int LEDR_WIDTH      = 10,
    parameter int LEDG_WIDTH      = 8,
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wrMEM,
    input  logic                      rdMEM,
    input  logic [DATA_BIT_WIDTH-1:0] addr,
    input  logic [DATA_BIT_WIDTH-1:0] wrData,
    input  logic [DATA_BIT_WIDTH-1:0] memRdData,
    input  logic [SW_WIDTH-1:0]       switchesIn,
    output logic                      memWe,
    output logic [DATA_BIT_WIDTH-1:0] rdData,
    output logic                      rdValid,
    output logic [HEX_WIDTH-1:0]      hexOut,
    output logic [LEDR_WIDTH-1:0]     ledrOut,
    output logic [LEDG_WIDTH-1:0]     ledgOut,
    output logic                      swIrq
);

    logic                      is_io;
    logic [2:0]                off;
    logic [HEX_WIDTH-1:0]      hex_q, hex_d;
    logic [LEDR_WIDTH-1:0]     ledr_q, ledr_d;
    logic [LEDG_WIDTH-1:0]     ledg_q, ledg_d;
    logic                      flag_q, flag_d;
    logic                      rdv_q, rdv_d;
    logic                      sel_q, sel_d;
    logic [DATA_BIT_WIDTH-1:0] rio_q, rio_d;
    logic [SW_WIDTH-1:0]       sw_stable;
    logic                      sw_chg, sw_clr;
    logic                      unused_ok;

    assign is_io     = &addr[DATA_BIT_WIDTH-1 -: IO_REGION_BITS];
    assign off       = addr[4:2];
    assign memWe     = wrMEM & ~is_io;
    assign unused_ok = ^{addr, wrData};

    switch_debouncer #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .sw_i     (switchesIn),
        .stable_o (sw_stable),
        .chg_o    (sw_chg)
    );

    // Read word is built from current register values, so a same-cycle
    // write is not visible to the read.
    always_comb begin
        rio_d = '0;
        unique case (off)
            OFF_HEX:    rio_d[HEX_WIDTH-1:0]  = hex_q;
            OFF_LEDR:   rio_d[LEDR_WIDTH-1:0] = ledr_q;
            OFF_LEDG:   rio_d[LEDG_WIDTH-1:0] = ledg_q;
            OFF_SW:     rio_d[SW_WIDTH-1:0]   = sw_stable;
            OFF_SWSTAT: rio_d[SWSTAT_CHG_BIT] = flag_q;
            default:    rio_d = '0;
        endcase

        hex_d  = hex_q;
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        if (wrMEM && is_io) begin
            unique case (off)
                OFF_HEX:  hex_d  = wrData[HEX_WIDTH-1:0];
                OFF_LEDR: ledr_d = wrData[LEDR_WIDTH-1:0];
                OFF_LEDG: ledg_d = wrData[LEDG_WIDTH-1:0];
                default:  ;
            endcase
        end

        rdv_d  = rdMEM;
        sel_d  = rdMEM & is_io;
        sw_clr = rdMEM && is_io && (off == OFF_SWSTAT);
        flag_d = sw_chg ? 1'b1 : (sw_clr ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex_q  <= '0;
            ledr_q <= '0;
            ledg_q <= '0;
            flag_q <= 1'b0;
            rdv_q  <= 1'b0;
            sel_q  <= 1'b0;
            rio_q  <= '0;
        end else begin
            hex_q  <= hex_d;
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            flag_q <= flag_d;
            rdv_q  <= rdv_d;
            sel_q  <= sel_d;
            rio_q  <= rio_d;
        end
    end

    assign rdData  = sel_q ? rio_q : memRdData;
    assign rdValid = rdv_q;
    assign hexOut  = hex_q;
    assign ledrOut = ledr_q;
    assign ledgOut = ledg_q;
    assign swIrq   = flag_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller: vector table for bus ops plus
// hand sequences for debounce, SWSTAT clear races and reset mid-burst.
module tb_io_bus_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wrMEM, rdMEM;
    logic [31:0] addr, wrData, memRdData;
    logic [9:0]  switchesIn;
    logic        memWe;
    logic [31:0] rdData;
    logic        rdValid;
    logic [15:0] hexOut;
    logic [9:0]  ledrOut;
    logic [7:0]  ledgOut;
    logic        swIrq;

    int n_tests = 0;
    int n_fail  = 0;

    io_bus_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wrMEM      (wrMEM),
        .rdMEM      (rdMEM),
        .addr       (addr),
        .wrData     (wrData),
        .memRdData  (memRdData),
        .switchesIn (switchesIn),
        .memWe      (memWe),
        .rdData     (rdData),
        .rdValid    (rdValid),
        .hexOut     (hexOut),
        .ledrOut    (ledrOut),
        .ledgOut    (ledgOut),
        .swIrq      (swIrq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        we;
        logic        rdv;
        logic [31:0] rdat;
        logic [15:0] hex;
        logic [9:0]  ledr;
        logic [7:0]  ledg;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d);
        wrMEM  = w;
        rdMEM  = r;
        addr   = a;
        wrData = d;
    endtask

    initial begin
        v[0]  = '{1, 0, 32'hF000_0000, 32'h1234, 0, 0, 0, 0,
                  16'h1234, 10'h000, 8'h00};
        v[1]  = '{0, 1, 32'hF000_0000, 0, 32'h9999, 0, 1, 32'h1234,
                  16'h1234, 10'h000, 8'h00};
        v[2]  = '{1, 0, 32'hF000_0004, 32'hFFFF_FFFF, 0, 0, 0, 0,
                  16'h1234, 10'h3FF, 8'h00};
        v[3]  = '{0, 1, 32'hF000_0004, 0, 0, 0, 1, 32'h3FF,
                  16'h1234, 10'h3FF, 8'h00};
        v[4]  = '{1, 0, 32'h0000_0040, 32'hDEAD, 0, 1, 0, 0,
                  16'h1234, 10'h3FF, 8'h00};
        v[5]  = '{0, 1, 32'h0000_0040, 0, 32'hCAFE_F00D, 0, 1,
                  32'hCAFE_F00D, 16'h1234, 10'h3FF, 8'h00};
        v[6]  = '{1, 0, 32'hF000_0008, 32'h1A5, 0, 0, 0, 0,
                  16'h1234, 10'h3FF, 8'hA5};
        v[7]  = '{0, 1, 32'hF000_0008, 0, 0, 0, 1, 32'hA5,
                  16'h1234, 10'h3FF, 8'hA5};
        v[8]  = '{1, 0, 32'hF000_000C, 32'hFFFF, 0, 0, 0, 0,
                  16'h1234, 10'h3FF, 8'hA5};
        v[9]  = '{0, 1, 32'hF000_000C, 0, 32'h77, 0, 1, 0,
                  16'h1234, 10'h3FF, 8'hA5};
        v[10] = '{0, 1, 32'hF000_001C, 0, 32'h55, 0, 1, 0,
                  16'h1234, 10'h3FF, 8'hA5};
        v[11] = '{1, 1, 32'hF000_0000, 32'hBEEF, 0, 0, 1, 32'h1234,
                  16'hBEEF, 10'h3FF, 8'hA5};
        v[12] = '{1, 0, 32'hE000_0000, 32'h77, 0, 1, 0, 0,
                  16'hBEEF, 10'h3FF, 8'hA5};
        v[13] = '{1, 0, 32'hF000_0010, 32'hFF, 0, 0, 0, 0,
                  16'hBEEF, 10'h3FF, 8'hA5};
        v[14] = '{0, 1, 32'hF000_0010, 0, 32'h1, 0, 1, 0,
                  16'hBEEF, 10'h3FF, 8'hA5};
        v[15] = '{0, 1, 32'h0000_0000, 0, 32'h1357_9BDF, 0, 1,
                  32'h1357_9BDF, 16'hBEEF, 10'h3FF, 8'hA5};

        reset_n    = 1'b0;
        memRdData  = '0;
        switchesIn = '0;
        op(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_rdValid", 32'(rdValid), 0);
        chk("rst_hex", 32'(hexOut), 0);
        chk("rst_ledr", 32'(ledrOut), 0);
        chk("rst_ledg", 32'(ledgOut), 0);
        chk("rst_swIrq", 32'(swIrq), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            op(v[i].wr, v[i].rd, v[i].a, v[i].wd);
            #1;
            chk($sformatf("v%0d_memWe", i), 32'(memWe), 32'(v[i].we));
            tick();
            op(0, 0, 0, 0);
            memRdData = v[i].mrd;
            #1;
            chk($sformatf("v%0d_rdValid", i), 32'(rdValid),
                32'(v[i].rdv));
            if (v[i].rdv)
                chk($sformatf("v%0d_rdData", i), rdData, v[i].rdat);
            chk($sformatf("v%0d_hex", i), 32'(hexOut), 32'(v[i].hex));
            chk($sformatf("v%0d_ledr", i), 32'(ledrOut), 32'(v[i].ledr));
            chk($sformatf("v%0d_ledg", i), 32'(ledgOut), 32'(v[i].ledg));
        end
        memRdData = '0;

        // back-to-back reads
        op(0, 1, 32'hF000_0000, 0);
        tick();
        chk("b2b0_valid", 32'(rdValid), 1);
        chk("b2b0_data", rdData, 32'hBEEF);
        op(0, 1, 32'hF000_0004, 0);
        tick();
        chk("b2b1_valid", 32'(rdValid), 1);
        chk("b2b1_data", rdData, 32'h3FF);
        op(0, 0, 0, 0);
        tick();
        chk("b2b_idle_valid", 32'(rdValid), 0);

        // debounce: stable after 2 sync + 4 window cycles
        switchesIn = 10'h005;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("deb_irq_k%0d", k), 32'(swIrq),
                (k == 6) ? 32'd1 : 32'd0);
        end
        op(0, 1, 32'hF000_0010, 0);
        tick();
        chk("sw_read", rdData, 32'h005);
        op(0, 1, 32'hF000_0014, 0);
        tick();
        chk("swstat_read", rdData, 32'h1);
        chk("swstat_clr", 32'(swIrq), 0);
        op(0, 0, 0, 0);

        // 3-cycle glitch is rejected
        switchesIn = 10'h007;
        repeat (3) tick();
        switchesIn = 10'h005;
        repeat (8) tick();
        chk("glitch_irq", 32'(swIrq), 0);
        op(0, 1, 32'hF000_0010, 0);
        tick();
        chk("glitch_sw", rdData, 32'h005);
        op(0, 0, 0, 0);

        // set wins over a same-cycle SWSTAT clear
        switchesIn = 10'h00A;
        repeat (6) tick();
        chk("re_irq", 32'(swIrq), 1);
        switchesIn = 10'h00B;
        repeat (5) tick();
        op(0, 1, 32'hF000_0014, 0);
        tick();
        chk("race_rd", rdData, 32'h1);
        chk("race_irq", 32'(swIrq), 1);
        tick();
        chk("race_rd2", rdData, 32'h1);
        chk("race_irq2", 32'(swIrq), 0);
        op(0, 1, 32'hF000_0010, 0);
        tick();
        chk("race_sw", rdData, 32'h00B);

        // reset in the middle of a read burst
        op(0, 1, 32'hF000_0008, 0);
        tick();
        chk("burst_valid", 32'(rdValid), 1);
        chk("burst_data", rdData, 32'hA5);
        reset_n = 1'b0;
        op(1, 1, 32'hF000_0000, 32'h4321);
        tick();
        chk("mrst_valid", 32'(rdValid), 0);
        chk("mrst_data", rdData, 0);
        chk("mrst_hex", 32'(hexOut), 0);
        chk("mrst_ledr", 32'(ledrOut), 0);
        chk("mrst_ledg", 32'(ledgOut), 0);
        chk("mrst_irq", 32'(swIrq), 0);
        op(1, 0, 32'h0000_0040, 32'h1);
        #1;
        chk("mrst_memWe", 32'(memWe), 1);
        op(0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_controller.md
IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 32: address and data bus width.
REQ-002 Parameter IO_REGION_BITS, default 4: count of top address bits that must all be 1 to select IO space.
REQ-003 Parameter HEX_WIDTH, default 16: seven-segment value register width (4 bits per digit).
REQ-004 Parameter LEDR_WIDTH, default 10; LEDG_WIDTH, default 8; SW_WIDTH, default 10: peripheral widths.
REQ-005 Parameter DEBOUNCE_CYCLES, default 4 (legal range 1..65535): switch stability window in clocks.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-008 wrMEM  in  1  store strobe for the current cycle.
REQ-009 rdMEM  in  1  load strobe for the current cycle.
REQ-010 addr  in  DATA_BIT_WIDTH  byte address; word offset is addr[4:2].
REQ-011 wrData  in  DATA_BIT_WIDTH  store data.
REQ-012 memRdData  in  DATA_BIT_WIDTH  data-memory read data, valid one cycle after the read.
REQ-013 switchesIn  in  SW_WIDTH  raw, asynchronous board switches.
REQ-014 memWe  out  1  data-memory write enable.
REQ-015 rdData  out  DATA_BIT_WIDTH  load result.
REQ-016 rdValid  out  1  one-cycle pulse qualifying rdData.
REQ-017 hexOut  out  HEX_WIDTH, ledrOut  out  LEDR_WIDTH, ledgOut  out  LEDG_WIDTH  registered peripheral outputs.
REQ-018 swIrq  out  1  level copy of the sticky switch-change flag.

Function
REQ-019 isIo SHALL be 1 when addr[DATA_BIT_WIDTH-1 -: IO_REGION_BITS] is all ones.
REQ-020 memWe SHALL be wrMEM & ~isIo, combinational, with no IO-register side effects.
REQ-021 IO word map (addr[4:2]): 0 HEX R/W; 1 LEDR R/W; 2 LEDG R/W; 4 SW read-only; 5 SWSTAT read-only (bit0 = change flag); 3, 6 and 7 read 0 and ignore writes.
REQ-022 An IO write SHALL update the selected register at the next edge from wrData LSBs; upper bits are dropped.
REQ-023 Writes to SW, SWSTAT or unmapped offsets SHALL change no state.
REQ-024 Reads SHALL have a latency of exactly 1: rdMEM at edge N gives rdValid=1 and rdData during cycle N+1.
REQ-025 rdData SHALL be the registered IO word, zero-extended, when the read hit IO; otherwise it SHALL be memRdData. The select is registered with the read.
REQ-026 Back-to-back reads SHALL be supported, one per cycle, with rdValid high on each following cycle.
REQ-027 rdValid SHALL be 0 in any cycle not preceded by rdMEM.
REQ-028 Simultaneous wrMEM and rdMEM to the same IO register SHALL perform the write. The read SHALL return the pre-write value.
REQ-029 switchesIn SHALL pass through a 2-flop synchronizer before any use.
REQ-030 Debounce: a per-bus counter SHALL reset whenever the synchronized sample differs from the previous sample.
REQ-031 The stable value SHALL take the sample once the sample has been unchanged and different from the stable value for DEBOUNCE_CYCLES consecutive cycles.
REQ-032 SW reads SHALL return the debounced stable value; the debounce counter SHALL saturate and never wrap.
REQ-033 The change flag SHALL set on any stable-value update.
REQ-034 A SWSTAT read SHALL clear the change flag, and the read SHALL return the pre-clear value.
REQ-035 If a set and a SWSTAT-read clear occur in the same cycle, the set SHALL win.
REQ-036 swIrq SHALL equal the change flag.

Reset
REQ-037 With reset_n=0 at an edge: hexOut=0, ledrOut=0, ledgOut=0, change flag=0, rdValid=0, rdData select=memory, debounce counter=0.
REQ-038 With reset_n=0 at an edge: the synchronizer flops and the stable value SHALL load 0.
REQ-039 Reset SHALL override any concurrent read or write, and a read issued in the reset cycle SHALL produce no rdValid.
REQ-040 memWe SHALL remain combinational and SHALL NOT be gated by reset.

Structure
REQ-041 Shared package io_map_pkg SHALL hold the word-offset constants (HEX, LEDR, LEDG, SW, SWSTAT) and the SWSTAT bit index.
REQ-042 The synchronizer and debounce logic SHALL be one sub-module, switch_debouncer, parametrised by SW_WIDTH and DEBOUNCE_CYCLES, with outputs for stable value and change pulse.

Verification
REQ-043 Reset, then write 0x1234 to 0xF0000000 -> next cycle hexOut=0x1234; read the same address -> rdValid=1 and rdData=0x00001234 one cycle later.
REQ-044 Write 0xFFFFFFFF to 0xF0000004 -> ledrOut=0x3FF; write to 0x00000040 -> memWe=1 for that cycle and no IO output changes.
REQ-045 switchesIn 0->0x005 held, DEBOUNCE_CYCLES=4 -> SW reads 0x005 exactly 2+4 cycles later and swIrq=1.
REQ-046 A glitch of 3 cycles then revert -> SW and swIrq unchanged.
REQ-047 Read SWSTAT with swIrq=1 -> rdData=1 and swIrq=0 next cycle; repeat the read with a simultaneous new stable change -> swIrq stays 1.
REQ-048 Assert reset_n=0 mid-burst of reads with LEDG=0xA5 -> rdValid=0 next cycle and all outputs 0.
